// File: rtl/sram_burst_pkg.sv
// Shared types and sizing helpers for the SRAM burst reader.
package sram_burst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    localparam int unsigned RdLatencyDefault = 2;
    localparam int unsigned SmallTileDepth   = 128;
    localparam int unsigned LargeTileDepth   = 512;

    // Macros shallower than one large tile are built from small tiles.
    function automatic int unsigned tile_depth_sel(input int unsigned depth);
        return (depth < LargeTileDepth) ? SmallTileDepth : LargeTileDepth;
    endfunction

    // One entry per presented read: tag marks a real issue, last marks the burst's final word.
    typedef struct packed {
        logic tag;
        logic last;
    } pipe_t;

endpackage

// File: rtl/sram_burst_reader_if.sv
// Command, SRAM wrapper and output stream signals of the burst reader.
interface sram_burst_reader_if #(
    parameter int unsigned DATA_BIT = 128,
    parameter int unsigned ADDR_BIT = 10,
    parameter int unsigned LEN_BIT  = 11
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_BIT-1:0] cmd_addr;
    logic [LEN_BIT-1:0]  cmd_len;

    logic [ADDR_BIT-1:0] sram_addr;
    logic                sram_ren;
    logic                sram_wen;
    logic [DATA_BIT-1:0] sram_rdata;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_BIT-1:0] out_data;
    logic                out_last;

    logic                done;
    logic                busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, sram_rdata, out_ready,
        output cmd_ready, sram_addr, sram_ren, sram_wen, out_valid, out_data, out_last, done, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, sram_rdata, out_ready,
        input  cmd_ready, sram_addr, sram_ren, sram_wen, out_valid, out_data, out_last, done, busy
    );

endinterface

// File: rtl/sram_burst_fifo.sv
// Synchronous FIFO with occupancy count; the head entry is visible combinationally.
module sram_burst_fifo #(
    parameter int unsigned Width = 129,
    parameter int unsigned Depth = 4,
    localparam int unsigned CntBit = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [Width-1:0]  push_data,
    input  logic              pop,
    output logic [Width-1:0]  head,
    output logic [CntBit-1:0] count,
    output logic              empty
);

    localparam int unsigned PtrBit = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrBit-1:0] LastPtr = PtrBit'(Depth - 1);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrBit-1:0] wptr_q, rptr_q;
    logic [CntBit-1:0] count_q;
    logic              do_push, do_pop;

    assign do_push = push && (count_q != CntBit'(Depth));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrBit'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrBit'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntBit'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntBit'(1);
            end
        end
    end

    assign head  = mem_q[rptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read front-end for the single-port SRAM wrapper with credit-based issue and a
// valid/ready output stream. Define SRAM_BURST_PERF_EN to add saturating perf counters.
module sram_burst_reader
    import sram_burst_pkg::*;
#(
    parameter int unsigned DATA_BIT   = 128,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_BIT   = $clog2(DEPTH),
    parameter int unsigned TILE_DEPTH = tile_depth_sel(DEPTH),
    parameter int unsigned RD_LATENCY = RdLatencyDefault,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_BIT    = ADDR_BIT + 1
) (
    input logic                 clk,
    input logic                 rst_n,
    sram_burst_reader_if.master bus
`ifdef SRAM_BURST_PERF_EN
    ,
    output logic [31:0]         perf_words,
    output logic [31:0]         perf_stall,
    output logic [31:0]         perf_bubble
`endif
);

    localparam int unsigned TileBit    = $clog2(TILE_DEPTH);
    localparam int unsigned FifoCntBit = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CreditBit  = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

    state_e               state_q;
    logic [ADDR_BIT-1:0]  cur_q, cur_next, sram_addr_q;
    logic [LEN_BIT-1:0]   remain_q;
    logic                 hold_pend_q, sram_ren_q, done_q;
    pipe_t                issue_tag_q;
    pipe_t                pipe_q [RD_LATENCY];
    logic [CreditBit-1:0] inflight_cnt, credit_used;
    logic [FifoCntBit-1:0] fifo_cnt;
    logic [DATA_BIT:0]    fifo_head;
    logic                 fifo_empty, credit_ok, tile_end;
    logic                 do_issue, do_hold, pop, pop_last;

    // Every tagged read still in the pipe already owns a FIFO slot.
    always_comb begin
        inflight_cnt = CreditBit'(issue_tag_q.tag);
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight_cnt = inflight_cnt + CreditBit'(pipe_q[i].tag);
        end
    end

    assign credit_used = inflight_cnt + CreditBit'(fifo_cnt);
    assign credit_ok   = credit_used < CreditBit'(FIFO_DEPTH);
    assign tile_end    = (&cur_q[TileBit-1:0]) || (cur_q == ADDR_BIT'(DEPTH - 1));
    assign cur_next    = (cur_q == ADDR_BIT'(DEPTH - 1)) ? '0 : cur_q + ADDR_BIT'(1);
    assign do_hold     = (state_q == StIssue) &&
                         (hold_pend_q || (!credit_ok && issue_tag_q.tag));
    assign do_issue    = (state_q == StIssue) && !hold_pend_q && credit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            remain_q    <= '0;
            hold_pend_q <= 1'b0;
            sram_ren_q  <= 1'b0;
            sram_addr_q <= '0;
            issue_tag_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sram_ren_q  <= 1'b0;
                    issue_tag_q <= '0;
                    if (bus.cmd_valid) begin
                        if (bus.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_q       <= bus.cmd_addr;
                            remain_q    <= bus.cmd_len;
                            hold_pend_q <= 1'b0;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (do_hold) begin
                        // Re-present the previous address; its data is never tagged.
                        sram_ren_q  <= 1'b1;
                        issue_tag_q <= '0;
                        hold_pend_q <= 1'b0;
                        if (remain_q == '0) begin
                            state_q <= StDrain;
                        end
                    end else if (do_issue) begin
                        sram_ren_q  <= 1'b1;
                        sram_addr_q <= cur_q;
                        issue_tag_q <= '{tag: 1'b1, last: (remain_q == LEN_BIT'(1))};
                        cur_q       <= cur_next;
                        remain_q    <= remain_q - LEN_BIT'(1);
                        hold_pend_q <= (remain_q == LEN_BIT'(1)) || tile_end;
                    end else begin
                        sram_ren_q  <= 1'b0;
                        issue_tag_q <= '0;
                    end
                end
                StDrain: begin
                    sram_ren_q  <= 1'b0;
                    issue_tag_q <= '0;
                    if (pop_last) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= issue_tag_q;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    sram_burst_fifo #(
        .Width (DATA_BIT + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_q[RD_LATENCY-1].tag),
        .push_data ({pipe_q[RD_LATENCY-1].last, bus.sram_rdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt),
        .empty     (fifo_empty)
    );

    assign pop      = !fifo_empty && bus.out_ready;
    assign pop_last = pop && fifo_head[DATA_BIT];

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.sram_addr = sram_addr_q;
    assign bus.sram_ren  = sram_ren_q;
    assign bus.sram_wen  = 1'b0;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head[DATA_BIT-1:0];
    assign bus.out_last  = !fifo_empty && fifo_head[DATA_BIT];

`ifdef SRAM_BURST_PERF_EN
    logic [31:0] perf_words_q, perf_stall_q, perf_bubble_q;
    logic        do_stall;

    assign do_stall = (state_q == StIssue) && !hold_pend_q && !credit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words_q  <= '0;
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (pop && (perf_words_q != '1)) begin
                perf_words_q <= perf_words_q + 32'd1;
            end
            if (do_stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (do_hold && (perf_bubble_q != '1)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_words  = perf_words_q;
    assign perf_stall  = perf_stall_q;
    assign perf_bubble = perf_bubble_q;
`endif

endmodule

// File: tb/tb_sram_burst_reader.sv
// Directed bench for sram_burst_reader with a latency-2 SRAM model that returns addr as data.
module tb_sram_burst_reader;

    localparam int unsigned DATA_BIT = 128;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned ADDR_BIT = 10;
    localparam int unsigned LEN_BIT  = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_burst_reader_if #(
        .DATA_BIT (DATA_BIT),
        .ADDR_BIT (ADDR_BIT),
        .LEN_BIT  (LEN_BIT)
    ) bus ();

`ifdef SRAM_BURST_PERF_EN
    logic [31:0] perf_words, perf_stall, perf_bubble;
`endif

    sram_burst_reader #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SRAM_BURST_PERF_EN
        ,
        .perf_words  (perf_words),
        .perf_stall  (perf_stall),
        .perf_bubble (perf_bubble)
`endif
    );

    // SRAM model: data valid two cycles after addr/ren; idle cycles return a junk marker.
    logic [DATA_BIT-1:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= bus.sram_ren ? DATA_BIT'(bus.sram_addr) : DATA_BIT'(32'hDEAD);
        rd2 <= rd1;
    end
    assign bus.sram_rdata = rd2;

    int ren_log[$];
    int out_log[$];
    int last_log[$];
    int done_cnt;
    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sram_ren) ren_log.push_back(int'(bus.sram_addr));
            if (bus.out_valid && bus.out_ready) begin
                out_log.push_back(int'(bus.out_data[15:0]));
                last_log.push_back(int'(bus.out_last));
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, " length"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic check_last(input string tag);
        for (int i = 0; i < last_log.size(); i++) begin
            check($sformatf("%s last[%0d]", tag, i), 32'(last_log[i]),
                  32'(i == last_log.size() - 1));
        end
    endtask

    task automatic clear_logs();
        ren_log.delete();
        out_log.delete();
        last_log.delete();
        done_cnt = 0;
    endtask

    task automatic send_cmd(input int addr, input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = ADDR_BIT'(addr);
        bus.cmd_len   = LEN_BIT'(len);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " idle within budget"}, 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b0;
        done_cnt      = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst sram_ren", 32'(bus.sram_ren), 32'd0);
        check("rst sram_addr", 32'(bus.sram_addr), 32'd0);
        check("rst sram_wen", 32'(bus.sram_wen), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_last", 32'(bus.out_last), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst
        clear_logs();
        bus.out_ready = 1'b1;
        send_cmd(5, 4);
        check("A busy", 32'(bus.busy), 32'd1);
        check("A cmd_ready low", 32'(bus.cmd_ready), 32'd0);
        wait_idle("A", 60);
        exp_q = '{5, 6, 7, 8, 8};
        check_seq("A sram_addr", ren_log, exp_q);
        exp_q = '{5, 6, 7, 8};
        check_seq("A out_data", out_log, exp_q);
        check_last("A");
        check("A done count", 32'(done_cnt), 32'd1);
        check("A cmd_ready back", 32'(bus.cmd_ready), 32'd1);

        // Tile boundary
        clear_logs();
        send_cmd(510, 4);
        wait_idle("B", 60);
        exp_q = '{510, 511, 511, 512, 513, 513};
        check_seq("B sram_addr", ren_log, exp_q);
        exp_q = '{510, 511, 512, 513};
        check_seq("B out_data", out_log, exp_q);
        check_last("B");
        check("B done count", 32'(done_cnt), 32'd1);

        // Address wrap
        clear_logs();
        send_cmd(1022, 3);
        wait_idle("C", 60);
        exp_q = '{1022, 1023, 1023, 0, 0};
        check_seq("C sram_addr", ren_log, exp_q);
        exp_q = '{1022, 1023, 0};
        check_seq("C out_data", out_log, exp_q);
        check_last("C");
        check("C done count", 32'(done_cnt), 32'd1);

        // Backpressure: first word left unconsumed, issue must stop at the credit limit
        clear_logs();
        bus.out_ready = 1'b0;
        send_cmd(100, 16);
        repeat (20) @(posedge clk);
        #1;
        exp_q = '{100, 101, 102, 103, 103};
        check_seq("D stalled sram_addr", ren_log, exp_q);
        check("D ren idle in stall", 32'(bus.sram_ren), 32'd0);
        check("D out_valid", 32'(bus.out_valid), 32'd1);
        check("D head word", 32'(bus.out_data[15:0]), 32'd100);
        check("D busy", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b1;
        wait_idle("D", 300);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(100 + i);
        check_seq("D out_data", out_log, exp_q);
        check_last("D");
        check("D done count", 32'(done_cnt), 32'd1);

        // Empty burst
        clear_logs();
        send_cmd(7, 0);
        check("E done pulse", 32'(bus.done), 32'd1);
        check("E cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("E busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("E done clears", 32'(bus.done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("E no ren", 32'(ren_log.size()), 32'd0);
        check("E done count", 32'(done_cnt), 32'd1);

        // Reset mid-burst
        clear_logs();
        send_cmd(200, 8);
        n = 0;
        while (ren_log.size() < 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("F reached 3 issues", 32'(ren_log.size() >= 3), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("F rst sram_ren", 32'(bus.sram_ren), 32'd0);
        check("F rst sram_addr", 32'(bus.sram_addr), 32'd0);
        check("F rst out_valid", 32'(bus.out_valid), 32'd0);
        check("F rst out_last", 32'(bus.out_last), 32'd0);
        check("F rst busy", 32'(bus.busy), 32'd0);
        check("F rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("F rst done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        @(posedge clk); #1;
        send_cmd(300, 2);
        wait_idle("F", 60);
        exp_q = '{300, 301, 301};
        check_seq("F sram_addr", ren_log, exp_q);
        exp_q = '{300, 301};
        check_seq("F out_data", out_log, exp_q);
        check_last("F");
        check("F done count", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
